// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module : clk_div_pkg
// Brief  : Shared constants for the programmable clock/tick divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

  localparam int CNT_W_DEF = 28;

  // Half-period values for common rates from a 100 MHz system clock
  localparam int DIV_1HZ_100M  = 50_000_000;
  localparam int DIV_10HZ_100M = 5_000_000;
  localparam int DIV_1KHZ_100M = 50_000;

endpackage

`default_nettype wire

// File: rtl/clk_div_shadow.sv
// ============================================================================
// Module : clk_div_shadow
// Brief  : Holds a requested divisor until the counter core reaches a safe
//          boundary; generates div_ack / div_err. Macro: CLK_DIV_DUTY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_div_shadow
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CNT_W:0]   hi_val,
  output logic [CNT_W:0]   apply_hi,
`endif
  input  logic             boundary,
  output logic             apply,
  output logic [CNT_W-1:0] apply_div,
  output logic             div_ack,
  output logic             div_err
);

  logic [CNT_W-1:0] r_shadow;
  logic             r_pending;
  logic             w_load_ok;

`ifdef CLK_DIV_DUTY_EN
  logic [CNT_W:0] r_shadow_hi;
  logic [CNT_W:0] w_period;

  // High time must be non-zero and shorter than the full period 2N
  assign w_period  = {div_val, 1'b0};
  assign w_load_ok = (div_val != '0) && (hi_val != '0) && (hi_val < w_period);
  assign apply_hi  = r_shadow_hi;
`else
  assign w_load_ok = (div_val != '0);
`endif

  assign apply     = boundary & r_pending;
  assign apply_div = r_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
      div_ack   <= 1'b0;
      div_err   <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
      r_shadow_hi <= '0;
`endif
    end else begin
      div_ack <= apply;
      div_err <= div_load & ~w_load_ok;
      if (apply) begin
        r_pending <= 1'b0;
      end
      // A load coinciding with an apply is captured for the following boundary
      if (div_load && w_load_ok) begin
        r_shadow  <= div_val;
        r_pending <= 1'b1;
`ifdef CLK_DIV_DUTY_EN
        r_shadow_hi <= hi_val;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_divider_prog.sv
// ============================================================================
// Module : clk_divider_prog
// Brief  : Runtime-programmable square-wave / tick generator with glitch-free
//          divisor update. Macro CLK_DIV_DUTY_EN adds programmable duty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_1HZ_100M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CNT_W:0]   hi_val,
`endif
  output logic             div_ack,
  output logic             div_err,
  output logic             oclk,
  output logic             tick
);

`ifdef CLK_DIV_DUTY_EN
  localparam int CW = CNT_W + 1;
`else
  localparam int CW = CNT_W;
`endif

  localparam logic [CW-1:0]    C_ONE     = CW'(1);
  localparam logic [CNT_W-1:0] C_DIV_RST = CNT_W'(DIV_RST);

  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_div_active;
  logic             w_at_last;
  logic             w_boundary;
  logic             w_apply;
  logic [CNT_W-1:0] w_apply_div;

  // While disabled, a pending divisor may be applied at once
  assign w_boundary = en ? w_at_last : 1'b1;

`ifdef CLK_DIV_DUTY_EN
  logic [CNT_W:0] r_hi_active;
  logic [CNT_W:0] w_apply_hi;
  logic [CNT_W:0] w_hi_eff;
  logic [CW-1:0]  w_cnt_next;

  assign w_at_last  = (r_cnt == ({r_div_active, 1'b0} - C_ONE));
  assign w_cnt_next = w_at_last ? '0 : (r_cnt + C_ONE);
  assign w_hi_eff   = w_apply ? w_apply_hi : r_hi_active;
`else
  assign w_at_last  = (r_cnt == (r_div_active - C_ONE));
`endif

  clk_div_shadow #(
    .CNT_W (CNT_W)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .div_val   (div_val),
    .div_load  (div_load),
`ifdef CLK_DIV_DUTY_EN
    .hi_val    (hi_val),
    .apply_hi  (w_apply_hi),
`endif
    .boundary  (w_boundary),
    .apply     (w_apply),
    .apply_div (w_apply_div),
    .div_ack   (div_ack),
    .div_err   (div_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_div_active <= C_DIV_RST;
      oclk         <= 1'b0;
      tick         <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
      r_hi_active  <= {1'b0, C_DIV_RST};
`endif
    end else begin
      tick <= 1'b0;
      if (en) begin
`ifdef CLK_DIV_DUTY_EN
        r_cnt <= w_cnt_next;
        oclk  <= (w_cnt_next < w_hi_eff);
        tick  <= w_at_last;
        if (w_apply) begin
          r_div_active <= w_apply_div;
          r_hi_active  <= w_apply_hi;
        end
`else
        if (w_at_last) begin
          r_cnt <= '0;
          oclk  <= ~oclk;
          tick  <= ~oclk;
          if (w_apply) begin
            r_div_active <= w_apply_div;
          end
        end else begin
          r_cnt <= r_cnt + C_ONE;
        end
`endif
      end else if (w_apply) begin
        r_cnt        <= '0;
        r_div_active <= w_apply_div;
`ifdef CLK_DIV_DUTY_EN
        r_hi_active  <= w_apply_hi;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_divider_prog.sv
// ============================================================================
// Module : tb_clk_divider_prog
// Brief  : Directed + randomized check of clk_divider_prog (50% duty build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clk_divider_prog;

  localparam int CNT_W   = 8;
  localparam int DIV_RST = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             div_err;
  logic             oclk;
  logic             tick;
`ifdef CLK_DIV_DUTY_EN
  logic [CNT_W:0]   hi_val;
  assign hi_val = {1'b0, div_val};
`endif

  always #5 clk = ~clk;

  clk_divider_prog #(
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
`ifdef CLK_DIV_DUTY_EN
    .hi_val   (hi_val),
`endif
    .div_ack  (div_ack),
    .div_err  (div_err),
    .oclk     (oclk),
    .tick     (tick)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: elapsed cycles in the current half-period and its length
  int m_pos, m_half, m_shadow;
  bit m_pending, m_oclk, m_tick, m_ack, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit l, input int v);
    bit apply;
    if (r) begin
      m_pos = 0; m_oclk = 0; m_tick = 0; m_ack = 0; m_err = 0;
      m_half = DIV_RST; m_shadow = 0; m_pending = 0;
    end else begin
      apply  = 0;
      m_tick = 0;
      if (e) begin
        if (m_pos + 1 >= m_half) begin
          m_oclk = !m_oclk;
          m_pos  = 0;
          m_tick = m_oclk;
          apply  = m_pending;
        end else begin
          m_pos++;
        end
      end else if (m_pending) begin
        apply = 1;
        m_pos = 0;
      end
      m_ack = apply;
      m_err = l && (v == 0);
      if (apply) begin
        m_half    = m_shadow;
        m_pending = 0;
      end
      if (l && v != 0) begin
        m_shadow  = v;
        m_pending = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit l, input int v);
    rst      = r;
    en       = e;
    div_load = l;
    div_val  = v[CNT_W-1:0];
    @(posedge clk);
    model(r, e, l, v);
    #1;
    chk("oclk", 32'(oclk), 32'(m_oclk));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("div_ack", 32'(div_ack), 32'(m_ack));
    chk("div_err", 32'(div_err), 32'(m_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0);
  endtask

  int gap;
  int ack_count;

  initial begin
    rst = 1; en = 0; div_load = 0; div_val = '0;
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("reset_oclk", 32'(oclk), 32'd0);

    // Default half-period, then a load in the middle of a half-period
    run(12);
    step(0, 1, 1, 3);
    run(20);

    // Rejected zero load
    step(0, 1, 1, 0);
    run(10);

    // Two loads before one boundary: last wins, single ack
    step(0, 1, 1, 7);
    ack_count = 0;
    rst = 0; en = 1; div_load = 1; div_val = 8'd2;
    @(posedge clk); model(0, 1, 1, 2); #1;
    chk("double_load_ack", 32'(div_ack), 32'(m_ack));
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0);
      if (div_ack) ack_count++;
    end
    chk("single_ack", 32'(ack_count), 32'd1);

    // Tick spacing for N=2 must be 2N cycles
    gap = 0;
    while (!tick && gap < 20) begin step(0, 1, 0, 0); gap++; end
    gap = 0;
    do begin step(0, 1, 0, 0); gap++; end while (!tick && gap < 20);
    chk("tick_period_n2", 32'(gap), 32'd4);

    // Disabled: hold, then immediate apply of a new divisor
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 4);
    step(0, 0, 0, 0);
    chk("ack_while_disabled", 32'(div_ack), 32'd1);
    run(12);

    // Reset with a load pending
    step(0, 1, 1, 6);
    step(1, 1, 0, 0);
    chk("rst_clears_oclk", 32'(oclk), 32'd0);
    run(12);

    // N=1 gives a toggle every cycle
    step(0, 1, 1, 1);
    run(16);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
